// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU/MDU slice.
//   alu_op_e    - 5-bit opcode encoding (base ops 0x00-0x0D, M ops 0x10-0x17)
//   mdu_state_e - control FSM states of alu_mdu
//   is_muldiv() - true for any M-extension opcode
//   is_div()    - true for DIV/DIVU/REM/REMU
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'h00,
    OP_SUB    = 5'h01,
    OP_ADD    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLL    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_EQ     = 5'h08,
    OP_SLT    = 5'h09,
    OP_SLTU   = 5'h0A,
    OP_NE     = 5'h0B,
    OP_LT     = 5'h0C,
    OP_GE     = 5'h0D,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // M ops occupy 0x10-0x17, so the top two opcode bits identify them.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

  // Within the M set, bit 2 separates multiplies from divides.
  function automatic logic is_div(input logic [4:0] op);
    return is_muldiv(op) && op[2];
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational datapath for the base (single-cycle) ops.
//   src_a, src_b - operands
//   op           - 5-bit opcode; anything outside 0x00-0x0D yields 0
//   result       - combinational result (compares are zero-extended 0/1)
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [4:0]            op,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;
  logic           eq;

  assign shamt = src_b[SHW-1:0];
  assign lt_s  = $signed(src_a) < $signed(src_b);
  assign lt_u  = src_a < src_b;
  assign eq    = src_a == src_b;

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      OP_AND:       result = src_a & src_b;
      OP_SUB:       result = src_a - src_b;
      OP_ADD:       result = src_a + src_b;
      OP_OR:        result = src_a | src_b;
      OP_XOR:       result = src_a ^ src_b;
      OP_SLL:       result = src_a << shamt;
      OP_SRL:       result = src_a >> shamt;
      OP_SRA:       result = $signed(src_a) >>> shamt;
      OP_EQ:        result = {{(DATA_WIDTH-1){1'b0}}, eq};
      OP_SLT, OP_LT: result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      OP_SLTU:      result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      OP_NE:        result = {{(DATA_WIDTH-1){1'b0}}, ~eq};
      OP_GE:        result = {{(DATA_WIDTH-1){1'b0}}, ~lt_s};
      default:      result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: RV32I ALU plus iterative RV32M multiply/divide unit.
//   clk, reset          - clock and synchronous active-high reset
//   in_valid / in_ready - request handshake; SrcA, SrcB, Operation sampled on accept
//   out_valid/out_ready - result handshake; ALUResult held until taken
// Base ops, undefined opcodes and degenerate divides finish in one cycle;
// other M ops take DATA_WIDTH iterations of shift-add / restoring division
// on operand magnitudes, with the sign applied on the final iteration.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  mdu_state_e state, state_next;

  logic [CW-1:0] count;
  logic [W-1:0]  acc_hi;
  logic [W-1:0]  acc_lo;
  logic [W-1:0]  mcand;
  alu_op_e       op_q;
  logic          neg_res;
  logic          neg_rem;

  logic [4:0]    op_in;
  alu_op_e       op_in_e;
  logic          accept;
  logic [W-1:0]  base_result;

  logic          div_zero;
  logic          div_ovf;
  logic          special;
  logic [W-1:0]  special_result;

  logic          a_signed, b_signed;
  logic          sign_a, sign_b;
  logic [W-1:0]  mag_a, mag_b;

  logic [W:0]    mul_sum;
  logic [W:0]    div_trial;
  logic [W-1:0]  hi_n, lo_n;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]  quot_fix, rem_fix;
  logic [W-1:0]  final_result;

  assign op_in     = 5'(Operation);
  assign op_in_e   = alu_op_e'(op_in);
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  alu_comb #(.DATA_WIDTH(W)) u_alu_comb (
    .src_a  (SrcA),
    .src_b  (SrcB),
    .op     (op_in),
    .result (base_result)
  );

  // Degenerate divides never enter CALC; their results are fixed values.
  // Opcode bit 1 distinguishes REM/REMU from DIV/DIVU.
  assign div_zero = is_div(op_in) && (SrcB == '0);
  assign div_ovf  = ((op_in_e == OP_DIV) || (op_in_e == OP_REM)) &&
                    (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = op_in[1] ? SrcA : '1;
    else if (div_ovf)
      special_result = op_in[1] ? '0 : SrcA;
  end

  // Low half of MUL is sign-agnostic, so it shares the signed path.
  assign a_signed = op_in_e inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_signed = op_in_e inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign sign_a   = a_signed && SrcA[W-1];
  assign sign_b   = b_signed && SrcB[W-1];
  assign mag_a    = sign_a ? -SrcA : SrcA;
  assign mag_b    = sign_b ? -SrcB : SrcB;

  // One iteration. Multiply: {acc_hi,acc_lo} is product:multiplier, shifted
  // right each step. Divide: acc_hi is the partial remainder, acc_lo shifts
  // dividend bits out and quotient bits in. acc_hi < divisor always holds,
  // so the W+1-bit trial difference never overflows and its MSB is the borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_trial = {acc_hi, acc_lo[W-1]} - {1'b0, mcand};
    hi_n      = acc_hi;
    lo_n      = acc_lo;
    if (!op_q[2]) begin
      hi_n = mul_sum[W:1];
      lo_n = {mul_sum[0], acc_lo[W-1:1]};
    end else if (!div_trial[W]) begin
      hi_n = div_trial[W-1:0];
      lo_n = {acc_lo[W-2:0], 1'b1};
    end else begin
      hi_n = {acc_hi[W-2:0], acc_lo[W-1]};
      lo_n = {acc_lo[W-2:0], 1'b0};
    end
  end

  // Sign fix-up applied to the values produced by the last iteration.
  always_comb begin
    prod         = {hi_n, lo_n};
    prod_fix     = neg_res ? -prod : prod;
    quot_fix     = neg_res ? -lo_n : lo_n;
    rem_fix      = neg_rem ? -hi_n : hi_n;
    final_result = '0;
    case (op_q)
      OP_MUL:                       final_result = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              final_result = quot_fix;
      OP_REM, OP_REMU:              final_result = rem_fix;
      default:                      final_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (is_muldiv(op_in) && !special) ? CALC : DONE;
      CALC: if (count == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      mcand     <= '0;
      op_q      <= OP_AND;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      ALUResult <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op_in_e;
            count   <= CW'(W-1);
            acc_hi  <= '0;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            // Multiplies iterate over the multiplier (B); divides over the dividend (A).
            if (op_in[2]) begin
              mcand  <= mag_b;
              acc_lo <= mag_a;
            end else begin
              mcand  <= mag_a;
              acc_lo <= mag_b;
            end
            if (special)
              ALUResult <= special_result;
            else if (!is_muldiv(op_in))
              ALUResult <= base_result;
          end
        end
        CALC: begin
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          if (count == '0)
            ALUResult <= final_result;
          else
            count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
